// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage and the stages that
// reuse its opcode length decoder.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        VEC_LO,
        VEC_HI,
        OPC,
        OPR1,
        OPR2,
        HOLD,
        DRAIN
    } fetch_state_e;

    localparam logic [1:0]  LEN1 = 2'd1;
    localparam logic [1:0]  LEN2 = 2'd2;
    localparam logic [1:0]  LEN3 = 2'd3;

    localparam logic [15:0] VECTOR_ADDR_DEFAULT = 16'hFFFC;

endpackage

// File: rtl/fetch_len.sv
// Opcode length decoder: maps an opcode byte to its total instruction length (1-3).
module fetch_len
    import fetch_unit_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic [1:0] len_o
);

    logic [3:0] lo;
    logic [3:0] hi;

    assign lo = opcode_i[3:0];
    assign hi = opcode_i[7:4];

    // One-byte cases take priority over the three-byte patterns.
    always_comb begin
        len_o = LEN2;
        if (lo == 4'h8 || lo == 4'hA ||
            opcode_i == 8'h00 || opcode_i == 8'h40 || opcode_i == 8'h60) begin
            len_o = LEN1;
        end else if (lo >= 4'hC ||
                     ((lo == 4'h9 || lo == 4'hB) && hi[0]) ||
                     opcode_i == 8'h20) begin
            len_o = LEN3;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the reset vector, then fetches 1-3 byte
// instructions and hands each one to the decoder over a valid/ready handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] VECTOR_ADDR = VECTOR_ADDR_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_req,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [7:0]  o_opcode,
    output logic [15:0] o_operand,
    output logic [1:0]  o_instr_len,
    output logic [15:0] o_instr_pc,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  addr_q, addr_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic [7:0]   opcode_q, opcode_d;
    logic [15:0]  operand_q, operand_d;
    logic [1:0]   len_q, len_d;
    logic [15:0]  ipc_q, ipc_d;
    logic [1:0]   rdata_len;
    logic         acked;
    logic         redirect_taken;

    fetch_len u_len (
        .opcode_i (i_mem_rdata),
        .len_o    (rdata_len)
    );

    assign acked          = req_q && i_mem_ack;
    assign redirect_taken = i_redirect && state_q != VEC_LO && state_q != VEC_HI;

    // Request/address are registered so reset can hold them at zero; each
    // transition loads the address of the read that the next state performs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        req_d     = req_q;
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        len_d     = len_q;
        ipc_d     = ipc_q;

        if (redirect_taken) begin
            pc_d    = i_redirect_pc;
            valid_d = 1'b0;
            req_d   = 1'b1;
            if (req_q && !i_mem_ack) begin
                state_d = DRAIN;
            end else begin
                state_d = OPC;
                addr_d  = i_redirect_pc;
            end
        end else begin
            unique case (state_q)
                VEC_LO: begin
                    if (!req_q) begin
                        req_d  = 1'b1;
                        addr_d = VECTOR_ADDR;
                    end else if (acked) begin
                        pc_d[7:0] = i_mem_rdata;
                        state_d   = VEC_HI;
                        addr_d    = VECTOR_ADDR + 16'd1;
                    end
                end
                VEC_HI: begin
                    if (acked) begin
                        pc_d[15:8] = i_mem_rdata;
                        state_d    = OPC;
                        addr_d     = {i_mem_rdata, pc_q[7:0]};
                    end
                end
                OPC: begin
                    if (acked) begin
                        opcode_d  = i_mem_rdata;
                        ipc_d     = pc_q;
                        operand_d = '0;
                        len_d     = rdata_len;
                        if (rdata_len == LEN1) begin
                            state_d = HOLD;
                            req_d   = 1'b0;
                            valid_d = 1'b1;
                        end else begin
                            state_d = OPR1;
                            addr_d  = pc_q + 16'd1;
                        end
                    end
                end
                OPR1: begin
                    if (acked) begin
                        operand_d[7:0] = i_mem_rdata;
                        if (len_q == LEN2) begin
                            state_d = HOLD;
                            req_d   = 1'b0;
                            valid_d = 1'b1;
                        end else begin
                            state_d = OPR2;
                            addr_d  = pc_q + 16'd2;
                        end
                    end
                end
                OPR2: begin
                    if (acked) begin
                        operand_d[15:8] = i_mem_rdata;
                        state_d         = HOLD;
                        req_d           = 1'b0;
                        valid_d         = 1'b1;
                    end
                end
                HOLD: begin
                    if (i_instr_ready) begin
                        pc_d    = pc_q + {14'd0, len_q};
                        valid_d = 1'b0;
                        state_d = OPC;
                        req_d   = 1'b1;
                        addr_d  = pc_q + {14'd0, len_q};
                    end
                end
                DRAIN: begin
                    if (acked) begin
                        state_d = OPC;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = VEC_LO;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= VEC_LO;
            pc_q      <= '0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            operand_q <= '0;
            len_q     <= '0;
            ipc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            len_q     <= len_d;
            ipc_q     <= ipc_d;
        end
    end

    assign o_mem_addr    = addr_q;
    assign o_mem_req     = req_q;
    assign o_instr_valid = valid_q;
    assign o_opcode      = opcode_q;
    assign o_operand     = operand_q;
    assign o_instr_len   = len_q;
    assign o_instr_pc    = ipc_q;

endmodule
